minimization_equiv_checker: RTL



---
 rtl/minimization_pkg.sv | 21 ++
 rtl/minimization_equiv_checker_settle_timer.sv | 32 +++
 rtl/minimization_equiv_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/minimization_pkg.sv
// Shared types and defaults for the minimization equivalence checker.
// State encoding, default sizing and the settle-timer reload helper.
package minimization_pkg;

    localparam int N_INPUTS_DEF      = 3;
    localparam int SETTLE_CYCLES_DEF = 1;
    localparam int TIMER_W           = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter counts down to zero, so a hold of N cycles loads N-1.
    function automatic logic [TIMER_W-1:0] settle_reload(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/minimization_equiv_checker_settle_timer.sv
// Loadable down-counter that paces how long each stimulus vector is held.
// Load has priority over enable; the counter parks at zero.
module settle_timer
    import minimization_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               enable,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_r;

    // Zero flag straight from the count register.
    assign zero = (cnt_r == {TIMER_W{1'b0}});

    // Count register: reload, decrement or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_value;
        end else if (enable && !zero) begin
            cnt_r <= cnt_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/minimization_equiv_checker.sv
// Sweeps every input vector into an original and a minimized circuit and
// compares their outputs, reporting pass, mismatch count and first failure.
module minimization_equiv_checker
    import minimization_pkg::*;
#(
    parameter int N_INPUTS      = N_INPUTS_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                f_orig,
    input  logic                f_simp,
    output logic [N_INPUTS-1:0] vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   mismatch_count,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int CNT_W = N_INPUTS + 1;
    localparam logic [TIMER_W-1:0] RELOAD = settle_reload(SETTLE_CYCLES);

    state_t              state_r;
    logic [N_INPUTS-1:0] vec_r;
    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic [CNT_W-1:0]    mismatch_count_r;
    logic [N_INPUTS-1:0] first_fail_vec_r;
    logic                fail_seen_r;

    logic                timer_load_s;
    logic                timer_en_s;
    logic                timer_zero_s;
    logic                mismatch_s;
    logic                last_vec_s;
    logic [CNT_W-1:0]    count_next_s;

    assign vec            = vec_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign mismatch_count = mismatch_count_r;
    assign first_fail_vec = first_fail_vec_r;

    assign mismatch_s = f_orig ^ f_simp;
    assign last_vec_s = (vec_r == {N_INPUTS{1'b1}});

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load_s),
        .enable     (timer_en_s),
        .load_value (RELOAD),
        .zero       (timer_zero_s)
    );

    // Timer control and the mismatch count including the current sample.
    always_comb begin
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_r)
            S_IDLE:   timer_load_s = start;
            S_DONE:   timer_load_s = start;
            S_SETTLE: timer_en_s   = 1'b1;
            S_SAMPLE: timer_load_s = !last_vec_s;
            default: begin
                timer_load_s = 1'b0;
                timer_en_s   = 1'b0;
            end
        endcase
        if (mismatch_s) begin
            count_next_s = mismatch_count_r + {{N_INPUTS{1'b0}}, 1'b1};
        end else begin
            count_next_s = mismatch_count_r;
        end
    end

    // Sweep controller with all result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= S_IDLE;
            vec_r            <= {N_INPUTS{1'b0}};
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            mismatch_count_r <= {CNT_W{1'b0}};
            first_fail_vec_r <= {N_INPUTS{1'b0}};
            fail_seen_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    // A restart from DONE discards the previous results.
                    if (start) begin
                        state_r          <= S_SETTLE;
                        vec_r            <= {N_INPUTS{1'b0}};
                        busy_r           <= 1'b1;
                        done_r           <= 1'b0;
                        pass_r           <= 1'b0;
                        mismatch_count_r <= {CNT_W{1'b0}};
                        first_fail_vec_r <= {N_INPUTS{1'b0}};
                        fail_seen_r      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_SETTLE: begin
                    if (timer_zero_s) begin
                        state_r <= S_SAMPLE;
                    end else begin
                        state_r <= S_SETTLE;
                    end
                end
                S_SAMPLE: begin
                    mismatch_count_r <= count_next_s;
                    if (mismatch_s && !fail_seen_r) begin
                        first_fail_vec_r <= vec_r;
                        fail_seen_r      <= 1'b1;
                    end else begin
                        first_fail_vec_r <= first_fail_vec_r;
                    end
                    if (last_vec_s) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (count_next_s == {CNT_W{1'b0}});
                    end else begin
                        state_r <= S_SETTLE;
                        vec_r   <= vec_r + {{(N_INPUTS-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
